// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin packet arbiter merging two byte streams into one UART transmitter input.
// Define UART_ARB_TIMEOUT_EN to compile in the stalled-grant timeout (forced release + timeout_flag).
module uart_tx_arb #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      r0_data,
    input  logic            r0_valid,
    input  logic            r0_last,
    output logic            r0_ready,
    input  logic [7:0]      r1_data,
    input  logic            r1_valid,
    input  logic            r1_last,
    output logic            r1_ready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [1:0]      grant,
    input  logic [TO_W-1:0] timeout_cyc,
    output logic            timeout_flag
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] pkt_cnt_q, pkt_cnt_d;
    logic       xfer;
    logic       cur_last;
    logic       timeout_hit;

    assign xfer     = tx_valid & tx_ready;
    assign cur_last = (state_q == OWN1) ? r1_last : r0_last;
    assign grant    = {state_q == OWN1, state_q == OWN0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (r0_valid && r1_valid)
                    state_d = prio_q ? OWN1 : OWN0;
                else if (r0_valid)
                    state_d = OWN0;
                else if (r1_valid)
                    state_d = OWN1;
            end
            default: begin
                // Release on the last byte or on a stall timeout; the other side then gets priority.
                if ((xfer && cur_last) || timeout_hit) begin
                    state_d = IDLE;
                    prio_d  = (state_q == OWN0);
                end
            end
        endcase

        if (state_d == IDLE)
            pkt_cnt_d = '0;
        else if (xfer && (pkt_cnt_q != 8'hFF))
            pkt_cnt_d = pkt_cnt_q + 8'd1;
        else
            pkt_cnt_d = pkt_cnt_q;
    end

    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        case (state_q)
            OWN0: begin
                tx_data  = r0_data;
                tx_valid = r0_valid;
                r0_ready = tx_ready;
            end
            OWN1: begin
                tx_data  = r1_data;
                tx_valid = r1_valid;
                r1_ready = tx_ready;
            end
            default: ;
        endcase
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            timeout_flag_q, timeout_flag_d;

    // The stall counter restarts on every grant and every accepted byte; a zero limit never fires.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        timeout_hit = 1'b0;
        if ((state_q == IDLE) || xfer)
            stall_cnt_d = '0;
        else if ((timeout_cyc != '0) && (stall_cnt_q == timeout_cyc - TO_W'(1)))
            timeout_hit = 1'b1;
        else
            stall_cnt_d = stall_cnt_q + TO_W'(1);
        timeout_flag_d = timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    // Without the timeout feature the limit input is read but has no effect.
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0 & (|timeout_cyc);
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scenarios plus a randomized run against a packet-level arbiter model.
// Builds with or without UART_ARB_TIMEOUT_EN; the timeout scenarios follow the macro.
module tb_uart_tx_arb;

    localparam int TO_W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      r0_data = 8'h00;
    logic            r0_valid = 1'b0;
    logic            r0_last = 1'b0;
    logic            r0_ready;
    logic [7:0]      r1_data = 8'h00;
    logic            r1_valid = 1'b0;
    logic            r1_last = 1'b0;
    logic            r1_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;
    logic [1:0]      grant;
    logic [TO_W-1:0] timeout_cyc = '0;
    logic            timeout_flag;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_arb #(.TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .r0_data(r0_data), .r0_valid(r0_valid), .r0_last(r0_last), .r0_ready(r0_ready),
        .r1_data(r1_data), .r1_valid(r1_valid), .r1_last(r1_last), .r1_ready(r1_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .timeout_cyc(timeout_cyc), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Clears all inputs, holds reset for two cycles and releases it on a falling edge.
    task automatic do_reset();
        r0_valid = 1'b0; r1_valid = 1'b0; r0_last = 1'b0; r1_last = 1'b0;
        r0_data = 8'h00; r1_data = 8'h00; tx_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1; r0_data = 8'hA5; r1_data = 8'h5A; tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vectors++;
            if ({grant, tx_valid, tx_data, r0_ready, r1_ready, timeout_flag} !== 14'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs: got grant=%b tx_valid=%b tx_data=%h r0_ready=%b r1_ready=%b flag=%b, expected all zero",
                         grant, tx_valid, tx_data, r0_ready, r1_ready, timeout_flag);
            end
        end
        rst = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL reset_first_prio: got grant=%b expected 01", grant);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] pkt [3];
        pkt = '{8'h41, 8'h42, 8'h43};
        do_reset();
        tx_ready = 1'b1; r0_valid = 1'b1; r0_data = pkt[0]; r0_last = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_latency: got grant=%b expected 00", grant);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r0_data = pkt[i]; r0_last = (i == 2);
            #1;
            vectors++;
            if ({grant, tx_valid, tx_data, r0_ready, r1_ready} !== {2'b01, 1'b1, pkt[i], 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL single_byte%0d: got grant=%b tx_valid=%b tx_data=%h r0_ready=%b r1_ready=%b expected 01 1 %h 1 0",
                         i, grant, tx_valid, tx_data, r0_ready, r1_ready, pkt[i]);
            end
        end
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_release: got grant=%b expected 00", grant);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [6];
        seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        do_reset();
        tx_ready = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; r0_last = 1'b1; r1_last = 1'b1;
        r0_data = 8'hA0; r1_data = 8'hB1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++;
            if (grant !== seq[i]) begin
                miscompares++;
                $display("[TB] FAIL rr_step%0d: got grant=%b expected %b", i, grant, seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [$];
        int idx = 0;
        do_reset();
        r1_valid = 1'b1; r1_last = 1'b0; r1_data = 8'h10;
        @(negedge clk);
        r0_valid = 1'b1; r0_last = 1'b1; r0_data = 8'hEE;
        #1;
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL b2b_grant: got grant=%b expected 10", grant);
        end
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            tx_ready = (cyc % 2 == 0);
            r1_data = 8'h10 + 8'(idx); r1_last = (idx == 3);
            #1;
            vectors++;
            if ({grant, r0_ready} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL b2b_hold: got grant=%b r0_ready=%b expected 10 0", grant, r0_ready);
            end
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                idx++;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got.size()) begin
                miscompares++;
                $display("[TB] FAIL b2b_order%0d: got no byte expected %h", i, 8'h10 + 8'(i));
            end else if (got[i] !== 8'h10 + 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_order%0d: got %h expected %h", i, got[i], 8'h10 + 8'(i));
            end
        end
        r1_valid = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL b2b_next_owner: got grant=%b expected 01", grant);
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int flags = 0;
        int first = -1;
        do_reset();
        timeout_cyc = 16'd5; tx_ready = 1'b1;
        r0_valid = 1'b1; r0_data = 8'h01; r0_last = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL to_grant: got grant=%b expected 01", grant);
        end
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b1; r1_last = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (timeout_flag === 1'b1) begin
                flags++;
                if (first < 0) first = n;
            end
            if (n == 5) begin
                vectors++;
                if ({grant, timeout_flag} !== 3'b001) begin
                    miscompares++;
                    $display("[TB] FAIL to_release: got grant=%b flag=%b expected 00 1", grant, timeout_flag);
                end
            end
            if (n == 6) begin
                vectors++;
                if ({grant, timeout_flag} !== 3'b100) begin
                    miscompares++;
                    $display("[TB] FAIL to_regrant: got grant=%b flag=%b expected 10 0", grant, timeout_flag);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (flags !== 1 || first !== 5) begin
            miscompares++;
            $display("[TB] FAIL to_pulse: got %0d pulses first at %0d expected 1 at 5", flags, first);
        end
        timeout_cyc = '0;
    endtask
`endif

    // Grant must survive a long stall when the timeout is off (zero limit or feature absent).
    task automatic test_timeout_disabled();
        do_reset();
`ifdef UART_ARB_TIMEOUT_EN
        timeout_cyc = '0;
`else
        timeout_cyc = 16'd5;
`endif
        tx_ready = 1'b1; r0_valid = 1'b1; r0_last = 1'b0; r0_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            #1;
            vectors++;
            if ({grant, timeout_flag} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d: got grant=%b flag=%b expected 01 0", n, grant, timeout_flag);
            end
            @(negedge clk);
        end
        timeout_cyc = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        tx_ready = 1'b1; r1_valid = 1'b1; r1_last = 1'b0; r1_data = 8'h20;
        @(negedge clk); #1;
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL midrst_grant: got grant=%b expected 10", grant);
        end
        @(negedge clk);
        r0_valid = 1'b1; r0_data = 8'h30; r0_last = 1'b0; r1_data = 8'h21;
        #3;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if ({grant, tx_valid, r0_ready, r1_ready} !== 5'b0) begin
                miscompares++;
                $display("[TB] FAIL midrst_drop%0d: got grant=%b tx_valid=%b r0_ready=%b r1_ready=%b expected all zero",
                         i, grant, tx_valid, r0_ready, r1_ready);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL midrst_prio: got grant=%b expected 01", grant);
        end
    endtask

    // Packet-level reference: who owns the link, whose turn is next, how long the owner has stalled.
    task automatic test_random();
        int   owner = -1;
        int   turn = 0;
        int   stalled = 0;
        bit   flag_now = 1'b0;
        bit   flag_next;
        bit   moved;
        logic [1:0] e_grant;
        logic [7:0] e_data;
        logic e_valid, e_r0r, e_r1r;
        do_reset();
        timeout_cyc = 16'd3;
        for (int cyc = 0; cyc < 500; cyc++) begin
            r0_valid = ($urandom_range(0, 3) != 0);
            r1_valid = ($urandom_range(0, 3) != 0);
            r0_last  = ($urandom_range(0, 3) == 0);
            r1_last  = ($urandom_range(0, 3) == 0);
            r0_data  = 8'($urandom);
            r1_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) != 0);
            #1;
            e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            e_valid = (owner == 0) ? r0_valid : (owner == 1) ? r1_valid : 1'b0;
            e_data  = (owner == 0) ? r0_data : (owner == 1) ? r1_data : 8'h00;
            e_r0r   = (owner == 0) ? tx_ready : 1'b0;
            e_r1r   = (owner == 1) ? tx_ready : 1'b0;
            vectors++;
            if ({grant, tx_valid, tx_data, r0_ready, r1_ready, timeout_flag} !==
                {e_grant, e_valid, e_data, e_r0r, e_r1r, flag_now}) begin
                miscompares++;
                $display("[TB] FAIL random_cyc%0d: got g=%b v=%b d=%h r0r=%b r1r=%b f=%b expected g=%b v=%b d=%h r0r=%b r1r=%b f=%b",
                         cyc, grant, tx_valid, tx_data, r0_ready, r1_ready, timeout_flag,
                         e_grant, e_valid, e_data, e_r0r, e_r1r, flag_now);
            end
            flag_next = 1'b0;
            if (owner < 0) begin
                if (r0_valid && r1_valid) owner = turn;
                else if (r0_valid) owner = 0;
                else if (r1_valid) owner = 1;
                stalled = 0;
            end else begin
                moved = e_valid && tx_ready;
                if (moved && ((owner == 0) ? r0_last : r1_last)) begin
                    turn = 1 - owner;
                    owner = -1;
                end else if (moved) begin
                    stalled = 0;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (timeout_cyc != 0 && stalled + 1 == int'(timeout_cyc)) begin
                    turn = 1 - owner;
                    owner = -1;
                    flag_next = 1'b1;
`endif
                end else begin
                    stalled++;
                end
            end
            flag_now = flag_next;
            @(negedge clk);
        end
        timeout_cyc = '0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_back_to_back();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_timeout_disabled();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
